proc_ctrl_seq: RTL and testbench



---
 rtl/proc_ctrl_seq.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_proc_ctrl_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/proc_ctrl_seq.sv
// ---------------------------------------------------------------------------
// proc_ctrl_seq -- multi-cycle control unit for the 32-bit cs147sec05 datapath.
//
// Steps every instruction through FETCH -> DECODE -> EXECUTE -> MEMORY ->
// WRITEBACK, one cycle each. All outputs are registered: at every edge the
// next state is chosen, the control word for that next state is decoded from
// INSTRUCTION/ZERO, and both are captured together. Outputs therefore change
// only on a CLK edge or on reset.
//
// Ports:
//   CLK          clock, rising edge
//   RST          asynchronous active-low reset
//   INSTRUCTION  current IR contents from the datapath
//   ZERO         ALU zero flag (sampled for the WRITEBACK branch decision)
//   CTRL         29-bit datapath control word
//   READ/WRITE   memory strobes (never both high)
//   STATE        current state, for debug
//   ILLEGAL      (PROC_CTRL_ILLEGAL_TRAP_EN only) high while halted
//
// Optional build macro PROC_CTRL_ILLEGAL_TRAP_EN: an unknown opcode/funct seen
// in DECODE sends the sequencer to a sticky HALT state (encoding 5) with
// CTRL=0 and ILLEGAL=1 until reset. Without it, unknown instructions run as
// NOPs (PC+1, no register or memory write).
// ---------------------------------------------------------------------------
module proc_ctrl_seq #(
    parameter int          CTRL_W  = 29,
    parameter int          DATA_W  = 32,
    parameter logic [5:0]  ALU_ADD = 6'd1,
    parameter logic [5:0]  ALU_SUB = 6'd2,
    parameter logic [5:0]  ALU_MUL = 6'd3,
    parameter logic [5:0]  ALU_SHR = 6'd4,
    parameter logic [5:0]  ALU_SHL = 6'd5,
    parameter logic [5:0]  ALU_AND = 6'd6,
    parameter logic [5:0]  ALU_OR  = 6'd7,
    parameter logic [5:0]  ALU_NOR = 6'd8,
    parameter logic [5:0]  ALU_SLT = 6'd9
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] INSTRUCTION,
    input  logic              ZERO,
    output logic [CTRL_W-1:0] CTRL,
    output logic              READ,
    output logic              WRITE,
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    output logic              ILLEGAL,
`endif
    output logic [2:0]        STATE
);

    // Control word bit map
    localparam int PC_LOAD  = 0;
    localparam int PC_SEL_1 = 1;
    localparam int PC_SEL_2 = 2;
    localparam int PC_SEL_3 = 3;
    localparam int IR_LOAD  = 4;
    localparam int R1_SEL_1 = 5;
    localparam int REG_R    = 6;
    localparam int REG_W    = 7;
    localparam int SP_LOAD  = 8;
    localparam int OP1_SEL1 = 9;
    localparam int OP2_SEL1 = 10;
    localparam int OP2_SEL2 = 11;
    localparam int OP2_SEL3 = 12;
    localparam int OP2_SEL4 = 13;
    localparam int ALU_LO   = 14;
    localparam int ALU_HI   = 19;
    localparam int MA_SEL_1 = 20;
    localparam int MA_SEL_2 = 21;
    localparam int MD_SEL_1 = 22;
    localparam int WD_SEL_1 = 23;
    localparam int WD_SEL_2 = 24;
    localparam int WD_SEL_3 = 25;
    localparam int WA_SEL_1 = 26;
    localparam int WA_SEL_2 = 27;
    localparam int WA_SEL_3 = 28;

`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2,
        S_MEMORY = 3'd3, S_WRITEBACK = 3'd4, S_HALT = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2,
        S_MEMORY = 3'd3, S_WRITEBACK = 3'd4
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              read_q, read_d;
    logic              write_q, write_d;

    // ---------------- instruction decode ----------------
    logic [5:0] opcode, funct;
    logic [5:0] alu_op;
    logic r_alu, shift, jr, i_sext, i_zext, lui, lw, sw;
    logic beq, bne, push, pop, jmp, jal;
    logic unused_bits;

    assign opcode      = INSTRUCTION[31:26];
    assign funct       = INSTRUCTION[5:0];
    assign unused_bits = ^{INSTRUCTION[DATA_W-1:32], INSTRUCTION[25:6]};

    always_comb begin
        alu_op = '0;
        r_alu  = 1'b0; shift  = 1'b0; jr   = 1'b0;
        i_sext = 1'b0; i_zext = 1'b0; lui  = 1'b0;
        lw     = 1'b0; sw     = 1'b0;
        beq    = 1'b0; bne    = 1'b0;
        push   = 1'b0; pop    = 1'b0;
        jmp    = 1'b0; jal    = 1'b0;
        if (opcode == 6'h00) begin
            case (funct)
                6'h20: begin r_alu = 1'b1; alu_op = ALU_ADD; end
                6'h22: begin r_alu = 1'b1; alu_op = ALU_SUB; end
                6'h2c: begin r_alu = 1'b1; alu_op = ALU_MUL; end
                6'h24: begin r_alu = 1'b1; alu_op = ALU_AND; end
                6'h25: begin r_alu = 1'b1; alu_op = ALU_OR;  end
                6'h27: begin r_alu = 1'b1; alu_op = ALU_NOR; end
                6'h2a: begin r_alu = 1'b1; alu_op = ALU_SLT; end
                6'h01: begin shift = 1'b1; alu_op = ALU_SHL; end
                6'h02: begin shift = 1'b1; alu_op = ALU_SHR; end
                6'h08: jr = 1'b1;
                default: ;
            endcase
        end else begin
            case (opcode)
                6'h08: begin i_sext = 1'b1; alu_op = ALU_ADD; end
                6'h1d: begin i_sext = 1'b1; alu_op = ALU_MUL; end
                6'h0a: begin i_sext = 1'b1; alu_op = ALU_SLT; end
                6'h23: begin i_sext = 1'b1; lw = 1'b1; alu_op = ALU_ADD; end
                6'h2b: begin i_sext = 1'b1; sw = 1'b1; alu_op = ALU_ADD; end
                6'h0c: begin i_zext = 1'b1; alu_op = ALU_AND; end
                6'h0d: begin i_zext = 1'b1; alu_op = ALU_OR;  end
                6'h0f: lui = 1'b1;
                6'h04: begin beq  = 1'b1; alu_op = ALU_SUB; end
                6'h05: begin bne  = 1'b1; alu_op = ALU_SUB; end
                6'h1b: begin push = 1'b1; alu_op = ALU_SUB; end
                6'h1c: begin pop  = 1'b1; alu_op = ALU_ADD; end
                6'h02: jmp = 1'b1;
                6'h03: jal = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    logic legal;
    assign legal = r_alu | shift | jr | i_sext | i_zext | lui |
                   beq | bne | push | pop | jmp | jal;
`endif

    // ---------------- next state ----------------
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = S_DECODE;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
            S_DECODE:    state_d = legal ? S_EXECUTE : S_HALT;
            S_HALT:      state_d = S_HALT;
`else
            S_DECODE:    state_d = S_EXECUTE;
`endif
            S_EXECUTE:   state_d = S_MEMORY;
            S_MEMORY:    state_d = S_WRITEBACK;
            S_WRITEBACK: state_d = S_FETCH;
            default:     state_d = S_FETCH;
        endcase
    end

    // ---------------- control word for the next state ----------------
    always_comb begin
        ctrl_d  = '0;
        read_d  = 1'b0;
        write_d = 1'b0;

        // ALU operation and operand selects are set in EXECUTE and held
        // until the instruction retires so the result stays stable.
        if (state_d == S_EXECUTE || state_d == S_MEMORY || state_d == S_WRITEBACK) begin
            ctrl_d[ALU_HI:ALU_LO] = alu_op;
            if (r_alu || beq || bne) ctrl_d[OP2_SEL4] = 1'b1;
            if (shift) begin
                ctrl_d[OP2_SEL3] = 1'b1;
                ctrl_d[OP2_SEL1] = 1'b1;
            end
            if (i_sext) ctrl_d[OP2_SEL2] = 1'b1;
            if (push || pop) begin
                ctrl_d[OP1_SEL1] = 1'b1;   // operand 1 = sp
                ctrl_d[OP2_SEL3] = 1'b1;   // operand 2 = constant 1
            end
            // push stores r0; keep it selected until the write is done
            if (push) ctrl_d[R1_SEL_1] = 1'b1;
        end

        case (state_d)
            S_FETCH: begin
                read_d           = 1'b1;
                ctrl_d[MA_SEL_2] = 1'b1;
                ctrl_d[IR_LOAD]  = 1'b1;
            end
            S_DECODE, S_EXECUTE: begin
                ctrl_d[REG_R] = 1'b1;
                if (push) ctrl_d[R1_SEL_1] = 1'b1;
            end
            S_MEMORY: begin
                if (lw) begin
                    read_d = 1'b1;            // address = ALU result
                end else if (sw) begin
                    write_d = 1'b1;           // data = r2
                end else if (push) begin
                    write_d          = 1'b1;
                    ctrl_d[MA_SEL_1] = 1'b1;  // address = sp
                    ctrl_d[MD_SEL_1] = 1'b1;  // data = r1 (r0)
                    ctrl_d[SP_LOAD]  = 1'b1;
                end else if (pop) begin
                    read_d          = 1'b1;   // address = sp + 1 from ALU
                    ctrl_d[SP_LOAD] = 1'b1;
                end
            end
            S_WRITEBACK: begin
                ctrl_d[PC_LOAD]  = 1'b1;
                ctrl_d[PC_SEL_3] = 1'b1;
                ctrl_d[PC_SEL_1] = 1'b1;
                ctrl_d[WD_SEL_3] = 1'b1;
                if ((beq && ZERO) || (bne && !ZERO)) ctrl_d[PC_SEL_2] = 1'b1;
                if (jr)          ctrl_d[PC_SEL_1] = 1'b0;
                if (jmp || jal)  ctrl_d[PC_SEL_3] = 1'b0;
                if (r_alu || shift) begin
                    ctrl_d[REG_W]    = 1'b1;
                    ctrl_d[WA_SEL_3] = 1'b1;  // rd
                end
                if ((i_sext && !sw) || i_zext || lui) begin
                    ctrl_d[REG_W]    = 1'b1;
                    ctrl_d[WA_SEL_3] = 1'b1;  // rt
                    ctrl_d[WA_SEL_1] = 1'b1;
                end
                if (lw || pop) ctrl_d[WD_SEL_1] = 1'b1;
                if (lui)       ctrl_d[WD_SEL_2] = 1'b1;
                if (pop)       ctrl_d[REG_W]    = 1'b1;  // wa = r0
                if (jal) begin
                    ctrl_d[REG_W]    = 1'b1;
                    ctrl_d[WA_SEL_2] = 1'b1;  // r31
                    ctrl_d[WD_SEL_3] = 1'b0;  // PC + 1
                end
            end
            default: ;
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_FETCH;
            ctrl_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            read_q  <= read_d;
            write_q <= write_d;
        end
    end

`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) illegal_q <= 1'b0;
        else      illegal_q <= (state_d == S_HALT);
    end
    assign ILLEGAL = illegal_q;
`endif

    assign CTRL  = ctrl_q;
    assign READ  = read_q;
    assign WRITE = write_q;
    assign STATE = state_q;

endmodule

// File: tb/tb_proc_ctrl_seq.sv
// Directed bench for proc_ctrl_seq. Each instruction's expected per-cycle
// outputs (state, masked control bits, strobes) are queued when the
// instruction is applied and popped one per clock as the sequencer steps.
module tb_proc_ctrl_seq;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] INSTRUCTION = '0;
    logic        ZERO = 1'b0;
    logic [28:0] CTRL;
    logic        READ, WRITE;
    logic [2:0]  STATE;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    logic        ILLEGAL;
`endif

    proc_ctrl_seq dut (
        .CLK(CLK), .RST(RST), .INSTRUCTION(INSTRUCTION), .ZERO(ZERO),
        .CTRL(CTRL), .READ(READ), .WRITE(WRITE),
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
        .ILLEGAL(ILLEGAL),
`endif
        .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [28:0] mask;
        logic [28:0] val;
        logic        rd;
        logic        wr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [28:0] ALU_M = 29'h3F << 14;
    localparam logic [28:0] ALL   = '1;

    function automatic logic [28:0] b(input int i);
        logic [28:0] one = 29'd1;
        return one << i;
    endfunction

    function automatic logic [28:0] alu(input int v);
        return 29'(v) << 14;
    endfunction

    task automatic sb_push(input string tag, input logic [2:0] st, input logic [28:0] m,
                           input logic [28:0] v, input logic rd, input logic wr);
        exp_t e;
        e.tag = tag; e.st = st; e.mask = m; e.val = v; e.rd = rd; e.wr = wr;
        sb.push_back(e);
    endtask

    task automatic check(input exp_t e);
        n_cmp++;
        assert (STATE === e.st) else begin
            n_bad++;
            $error("FAIL %s.state: got %0d want %0d", e.tag, STATE, e.st);
        end
        n_cmp++;
        assert ((CTRL & e.mask) === e.val) else begin
            n_bad++;
            $error("FAIL %s.ctrl: got %h want %h (mask %h)", e.tag, CTRL & e.mask, e.val, e.mask);
        end
        n_cmp++;
        assert (READ === e.rd) else begin
            n_bad++;
            $error("FAIL %s.read: got %b want %b", e.tag, READ, e.rd);
        end
        n_cmp++;
        assert (WRITE === e.wr) else begin
            n_bad++;
            $error("FAIL %s.write: got %b want %b", e.tag, WRITE, e.wr);
        end
    endtask

    // One clock; compare after the edge has settled.
    task automatic step();
        exp_t e;
        @(posedge CLK);
        @(negedge CLK);
        n_cmp++;
        assert (sb.size() > 0) else begin
            n_bad++;
            $error("FAIL sb.empty: got 0 entries want >0");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Expected outputs on re-entering FETCH
    task automatic push_fetch(input string tag);
        sb_push({tag, ".F"}, 3'd0, b(4) | b(21) | b(7) | b(0), b(4) | b(21), 1'b1, 1'b0);
    endtask

    exp_t now;

    initial begin
        // ---- reset ----
        repeat (2) @(negedge CLK);
        now = '{"reset", 3'd0, ALL, 29'd0, 1'b0, 1'b0};
        check(now);
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
        n_cmp++;
        assert (ILLEGAL === 1'b0) else begin
            n_bad++; $error("FAIL reset.illegal: got %b want 0", ILLEGAL);
        end
`endif
        RST = 1'b1;

        // ---- addi r1,r0,5 ----
        INSTRUCTION = 32'h20010005; ZERO = 1'b0;
        sb_push("addi.D", 3'd1, b(6) | b(5), b(6), 1'b0, 1'b0);
        sb_push("addi.E", 3'd2, ALU_M | b(11) | b(13) | b(12), alu(1) | b(11), 1'b0, 1'b0);
        sb_push("addi.M", 3'd3, b(8), 29'd0, 1'b0, 1'b0);
        sb_push("addi.W", 3'd4, b(7) | b(28) | b(26) | b(27) | b(0) | b(3) | b(2) | b(1),
                b(7) | b(28) | b(26) | b(0) | b(3) | b(1), 1'b0, 1'b0);
        push_fetch("addi");
        steps(5);

        // ---- beq r1,r2,+4 taken ----
        INSTRUCTION = 32'h10220004; ZERO = 1'b1;
        sb_push("beq1.D", 3'd1, b(6), b(6), 1'b0, 1'b0);
        sb_push("beq1.E", 3'd2, ALU_M | b(13), alu(2) | b(13), 1'b0, 1'b0);
        sb_push("beq1.M", 3'd3, 29'd0, 29'd0, 1'b0, 1'b0);
        sb_push("beq1.W", 3'd4, b(2) | b(3) | b(0) | b(7), b(2) | b(3) | b(0), 1'b0, 1'b0);
        push_fetch("beq1");
        steps(5);

        // ---- beq not taken ----
        ZERO = 1'b0;
        sb_push("beq0.D", 3'd1, b(6), b(6), 1'b0, 1'b0);
        sb_push("beq0.E", 3'd2, ALU_M, alu(2), 1'b0, 1'b0);
        sb_push("beq0.M", 3'd3, 29'd0, 29'd0, 1'b0, 1'b0);
        sb_push("beq0.W", 3'd4, b(2) | b(3) | b(1) | b(0), b(3) | b(1) | b(0), 1'b0, 1'b0);
        push_fetch("beq0");
        steps(5);

        // ---- push ----
        INSTRUCTION = 32'h6C000000;
        sb_push("push.D", 3'd1, b(6) | b(5), b(6) | b(5), 1'b0, 1'b0);
        sb_push("push.E", 3'd2, ALU_M | b(9) | b(12) | b(13) | b(10),
                alu(2) | b(9) | b(12), 1'b0, 1'b0);
        sb_push("push.M", 3'd3, b(8) | b(20) | b(22), b(8) | b(20) | b(22), 1'b0, 1'b1);
        sb_push("push.W", 3'd4, b(7) | b(0), b(0), 1'b0, 1'b0);
        push_fetch("push");
        steps(5);

        // ---- jal 0x000100 ----
        INSTRUCTION = 32'h0C000100;
        sb_push("jal.D", 3'd1, b(6), b(6), 1'b0, 1'b0);
        sb_push("jal.E", 3'd2, ALU_M, 29'd0, 1'b0, 1'b0);
        sb_push("jal.M", 3'd3, 29'd0, 29'd0, 1'b0, 1'b0);
        sb_push("jal.W", 3'd4, b(3) | b(7) | b(27) | b(25) | b(28) | b(0),
                b(7) | b(27) | b(0), 1'b0, 1'b0);
        push_fetch("jal");
        steps(5);

        // ---- sw, abandoned by reset in EXECUTE ----
        INSTRUCTION = 32'hAC220008;
        sb_push("swr.D", 3'd1, b(6), b(6), 1'b0, 1'b0);
        sb_push("swr.E", 3'd2, ALU_M | b(11), alu(1) | b(11), 1'b0, 1'b0);
        steps(2);
        #1 RST = 1'b0;
        #1;
        now = '{"rst_async", 3'd0, ALL, 29'd0, 1'b0, 1'b0};
        check(now);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        now = '{"rst_hold", 3'd0, ALL, 29'd0, 1'b0, 1'b0};
        check(now);
        RST = 1'b1;
        // sw re-runs from DECODE after release
        sb_push("sw.D", 3'd1, b(6), b(6), 1'b0, 1'b0);
        sb_push("sw.E", 3'd2, ALU_M | b(11), alu(1) | b(11), 1'b0, 1'b0);
        sb_push("sw.M", 3'd3, b(22) | b(20) | b(21), 29'd0, 1'b0, 1'b1);
        sb_push("sw.W", 3'd4, b(7) | b(0), b(0), 1'b0, 1'b0);
        push_fetch("sw");
        steps(5);

        // ---- unknown opcode 0x3F ----
        INSTRUCTION = 32'hFC000000;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
        sb_push("ill.D", 3'd1, b(6), b(6), 1'b0, 1'b0);
        step();
        for (int i = 0; i < 10; i++) begin
            sb_push("ill.H", 3'd5, ALL, 29'd0, 1'b0, 1'b0);
            step();
            n_cmp++;
            assert (ILLEGAL === 1'b1) else begin
                n_bad++; $error("FAIL ill.flag: got %b want 1", ILLEGAL);
            end
        end
`else
        sb_push("nop.D", 3'd1, b(6), b(6), 1'b0, 1'b0);
        sb_push("nop.E", 3'd2, ALU_M | b(10) | b(11) | b(12) | b(13), 29'd0, 1'b0, 1'b0);
        sb_push("nop.M", 3'd3, b(8), 29'd0, 1'b0, 1'b0);
        sb_push("nop.W", 3'd4, b(0) | b(1) | b(2) | b(3) | b(7),
                b(0) | b(1) | b(3), 1'b0, 1'b0);
        push_fetch("nop");
        steps(5);
`endif

        n_cmp++;
        assert (sb.size() == 0) else begin
            n_bad++; $error("FAIL sb.leftover: got %0d want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
